// File: rtl/fe_sq_arbiter.sv
// fe_sq_arbiter: round-robin front end that shares one sequential fe_sq
// squarer among NUM_REQ requesters. The winner's operand is latched at grant,
// the fe_sq start/done handshake is run, and the result is returned on resp_h
// with a per-requester resp_done level.
//
// Handshakes:
//   - Requester side (4-phase): the requester raises req_valid[i] and holds it,
//     together with its req_f slice, until resp_done[i] rises. It then drops
//     req_valid[i], and resp_done[i] falls one cycle later.
//   - fe_sq side: sq_start is a one-cycle pulse, and sq_f is held from ISSUE
//     through WAIT. sq_h is taken only in the cycle where sq_done=1 while in
//     WAIT.
//
// Optional feature: define FE_SQ_ARB_STATS_EN to add stat_clr, stat_ops and
// stat_busy. These are saturating counters for completed operations and busy
// cycles.
module fe_sq_arbiter #(
    parameter int  NUM_REQ = 4,
    parameter int  WIDTH   = 320,
    localparam int IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
`ifdef FE_SQ_ARB_STATS_EN
    input  logic                     stat_clr,
    output logic [31:0]              stat_ops,
    output logic [31:0]              stat_busy,
`endif
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_f,
    output logic [NUM_REQ-1:0]       resp_done,
    output logic [WIDTH-1:0]         resp_h,
    output logic                     busy,
    output logic [IDW-1:0]           grant_id,
    output logic                     sq_start,
    output logic [WIDTH-1:0]         sq_f,
    input  logic                     sq_done,
    input  logic [WIDTH-1:0]         sq_h
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t               state_q, state_d;
    logic [IDW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]       grant_id_q, grant_id_d;
    logic [WIDTH-1:0]     operand_q, operand_d;
    logic [WIDTH-1:0]     resp_h_q, resp_h_d;
    logic [NUM_REQ-1:0]   resp_done_q, resp_done_d;
    logic                 sq_start_q, sq_start_d;
    logic                 busy_q, busy_d;
    logic                 pick_found;
    logic [IDW-1:0]       pick_id;
`ifdef FE_SQ_ARB_STATS_EN
    logic [31:0]          stat_ops_q, stat_ops_d;
    logic [31:0]          stat_busy_q, stat_busy_d;
`endif

    // Round-robin search: first requester at or after rr_ptr, wrapping.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            int idx;
            idx = (int'(rr_ptr_q) + k) % NUM_REQ;
            if (!pick_found && req_valid[idx]) begin
                pick_found = 1'b1;
                pick_id    = IDW'(idx);
            end
        end
    end

    // Next-state and registered-output logic for the arbitration FSM.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_id_d = grant_id_q;
        operand_d  = operand_q;
        resp_h_d   = resp_h_q;
        case (state_q)
            S_IDLE: begin
                if (pick_found) begin
                    grant_id_d = pick_id;
                    operand_d  = req_f[int'(pick_id)*WIDTH +: WIDTH];
                    state_d    = S_ISSUE;
                end
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (sq_done) begin
                    resp_h_d = sq_h;
                    state_d  = S_RESP;
                end
            end
            S_RESP: begin
                // Leave only once the owner has withdrawn its request.
                if (!req_valid[grant_id_q]) begin
                    rr_ptr_d = (grant_id_q == IDW'(NUM_REQ - 1)) ? '0 : grant_id_q + IDW'(1);
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        sq_start_d  = (state_d == S_ISSUE);
        busy_d      = (state_d != S_IDLE);
        resp_done_d = '0;
        if (state_d == S_RESP) begin
            resp_done_d[grant_id_d] = 1'b1;
        end
    end

`ifdef FE_SQ_ARB_STATS_EN
    // Saturating statistics; a clear takes priority over a same-cycle increment.
    always_comb begin
        stat_ops_d  = stat_ops_q;
        stat_busy_d = stat_busy_q;
        if (stat_clr) begin
            stat_ops_d  = '0;
            stat_busy_d = '0;
        end else begin
            if (state_q == S_RESP && state_d == S_IDLE && stat_ops_q != 32'hFFFF_FFFF) begin
                stat_ops_d = stat_ops_q + 32'd1;
            end
            if (busy_q && stat_busy_q != 32'hFFFF_FFFF) begin
                stat_busy_d = stat_busy_q + 32'd1;
            end
        end
    end
`endif

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= '0;
            grant_id_q  <= '0;
            operand_q   <= '0;
            resp_h_q    <= '0;
            resp_done_q <= '0;
            sq_start_q  <= 1'b0;
            busy_q      <= 1'b0;
`ifdef FE_SQ_ARB_STATS_EN
            stat_ops_q  <= '0;
            stat_busy_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_id_q  <= grant_id_d;
            operand_q   <= operand_d;
            resp_h_q    <= resp_h_d;
            resp_done_q <= resp_done_d;
            sq_start_q  <= sq_start_d;
            busy_q      <= busy_d;
`ifdef FE_SQ_ARB_STATS_EN
            stat_ops_q  <= stat_ops_d;
            stat_busy_q <= stat_busy_d;
`endif
        end
    end

    assign resp_done = resp_done_q;
    assign resp_h    = resp_h_q;
    assign busy      = busy_q;
    assign grant_id  = grant_id_q;
    assign sq_start  = sq_start_q;
    assign sq_f      = operand_q;
`ifdef FE_SQ_ARB_STATS_EN
    assign stat_ops  = stat_ops_q;
    assign stat_busy = stat_busy_q;
`endif

endmodule
